// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: computes a + b + cin one 4-bit slice per clock,
// LSB first, behind a valid/ready handshake on both the operand side and
// the result side. The result stays on sum/cout until the next operation
// overwrites it.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry_reg;
    logic [IW-1:0]    idx;

    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [4:0]       slice_sum;
    logic             accept;
    logic             last_slice;
    logic             retire;

    assign accept     = in_valid & in_ready;
    assign retire     = out_valid & out_ready;
    assign last_slice = (idx == LAST_IDX);
    assign a_nib      = a_reg[{idx, 2'b00} +: 4];
    assign b_nib      = b_reg[{idx, 2'b00} +: 4];

    // 4-bit full add of the current slice plus the carry from the previous one
    always_comb begin
        slice_sum = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_reg};
    end

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: accept in IDLE, one slice per cycle in RUN, hold DONE until retired
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept)     next_state = RUN;
            RUN:  if (last_slice) next_state = DONE;
            DONE: if (retire)     next_state = IDLE;
            default:              next_state = IDLE;
        endcase
    end

    // Handshake and status outputs are plain decodes of the registered state
    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state == RUN);
        out_valid = (state == DONE);
    end

    // Datapath: capture operands on accept, then ripple one nibble per RUN cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
        end else if (state == IDLE) begin
            if (accept) begin
                a_reg     <= a;
                b_reg     <= b;
                carry_reg <= cin;
                idx       <= '0;
            end
        end else if (state == RUN) begin
            sum[{idx, 2'b00} +: 4] <= slice_sum[3:0];
            carry_reg              <= slice_sum[4];
            if (last_slice) begin
                cout <= slice_sum[4];
                idx  <= '0;
            end else begin
                idx  <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder at WIDTH=16: a table of operand
// sets with hand-computed sums, plus hand-written sequences for
// backpressure, back-to-back issue and reset abort.
module tb_nibble_serial_adder;

    localparam int WIDTH = 16;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
    } vec_t;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              cin;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  sum;
    logic              cout;
    logic              busy;

    int checks;
    int errors;

    vec_t vecs[8];

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Present an operand set at a falling edge, let it be accepted, then
    // withdraw in_valid and scramble the operand inputs
    task automatic applyStimulus(input logic [15:0] va, input logic [15:0] vb,
                                 input logic vcin);
        @(negedge clk);
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        cin      = vcin;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = ~va;
        b        = ~vb;
        cin      = ~vcin;
    endtask

    // From the falling edge after an accept, count falling edges until out_valid
    task automatic waitResult(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    // Main directed sequence
    initial begin
        int cyc;
        int acc2;
        bit seen;

        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b0;

        vecs[0] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[3] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[5] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0};
        vecs[6] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};
        vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_sum", 32'(sum), 32'd0);
        checkOutput("reset_cout", 32'(cout), 32'd0);
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin);
            checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 32'd1);
            waitResult(cyc);
            checkOutput($sformatf("vec%0d_latency", i), 32'(cyc), 32'd4);
            checkOutput($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].sum));
            checkOutput($sformatf("vec%0d_cout", i), 32'(cout), 32'(vecs[i].cout));
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            checkOutput($sformatf("vec%0d_retired", i), 32'(out_valid), 32'd0);
            checkOutput($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
        end

        // Reset abort mid-RUN; previous result is 0xFFFF/cout=1
        applyStimulus(16'hFFFF, 16'h0000, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("abort_partial_sum", 32'(sum), 32'h0000FF00);
        checkOutput("abort_busy_before", 32'(busy), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
        checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_sum", 32'(sum), 32'd0);
        checkOutput("abort_cout", 32'(cout), 32'd0);

        // Release reset together with a new operand set: accepted on the first edge
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = 1'b1;
        a         = 16'h0003;
        b         = 16'h0004;
        cin       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("post_reset_first_accept", 32'(busy), 32'd1);
        waitResult(cyc);
        checkOutput("post_reset_latency", 32'(cyc), 32'd4);
        checkOutput("post_reset_sum", 32'(sum), 32'h00000007);
        checkOutput("post_reset_cout", 32'(cout), 32'd0);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("post_reset_retired", 32'(out_valid), 32'd0);

        // Backpressure: result held while out_ready is low, new input ignored
        applyStimulus(16'h1000, 16'h2000, 1'b0);
        waitResult(cyc);
        checkOutput("bp_latency", 32'(cyc), 32'd4);
        in_valid = 1'b1;
        a        = 16'hAAAA;
        b        = 16'h5555;
        cin      = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput($sformatf("bp_hold%0d_valid", k), 32'(out_valid), 32'd1);
            checkOutput($sformatf("bp_hold%0d_in_ready", k), 32'(in_ready), 32'd0);
            checkOutput($sformatf("bp_hold%0d_sum", k), 32'(sum), 32'h00003000);
        end
        checkOutput("bp_cout", 32'(cout), 32'd0);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("bp_retired", 32'(out_valid), 32'd0);
        checkOutput("bp_in_ready", 32'(in_ready), 32'd1);
        checkOutput("bp_busy", 32'(busy), 32'd0);
        checkOutput("bp_sum_kept", 32'(sum), 32'h00003000);

        // Back-to-back: second operand set presented continuously
        @(negedge clk);
        in_valid  = 1'b1;
        a         = 16'h8000;
        b         = 16'h8000;
        cin       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        a    = 16'h00FF;
        b    = 16'h0001;
        cin  = 1'b0;
        seen = 1'b0;
        acc2 = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (out_valid && !seen) begin
                seen = 1'b1;
                checkOutput("b2b_first_latency", 32'(k), 32'd4);
                checkOutput("b2b_first_sum", 32'(sum), 32'h00000000);
                checkOutput("b2b_first_cout", 32'(cout), 32'd1);
            end else if (seen && busy) begin
                acc2 = k;
                break;
            end
        end
        checkOutput("b2b_accept_spacing", 32'(acc2), 32'd6);
        in_valid = 1'b0;
        waitResult(cyc);
        checkOutput("b2b_second_latency", 32'(cyc), 32'd4);
        checkOutput("b2b_second_sum", 32'(sum), 32'h00000100);
        checkOutput("b2b_second_cout", 32'(cout), 32'd0);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("b2b_retired", 32'(in_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
